// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, word type and icache arbiter state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM port status as seen by the memory-side controllers.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Icache fill arbiter state, shared with the memory controller and tracing.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } iarb_state_t;

endpackage

// File: rtl/icache_arbiter_rr_arb2.sv
// Two-way round-robin grant (combinational).
//   req  : request bits, bit n = requester n
//   last : requester served most recently; the other one wins a tie
//   gnt  : one-hot grant, or zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/icache_arbiter.sv
// Arbitrates instruction fills from two icaches onto the single shared RAM read port.
//   CLK, nRST        : clock, synchronous active-low reset
//   iREN, iaddr0/1   : per-core fill request and word address
//   iwait, iload0/1  : per-core wait (low for the completion cycle) and fill data
//   dbusy / ibusy    : data side owns RAM / a fill owns RAM
//   ramREN, ramaddr  : RAM read request
//   ramload, ramstate: RAM read data and status
module icache_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS       = 2,
  parameter logic        RESET_LAST = 1'b1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  word_t           iaddr0,
  input  word_t           iaddr1,
  output logic [CPUS-1:0] iwait,
  output word_t           iload0,
  output word_t           iload1,
  input  logic            dbusy,
  output logic            ibusy,
  output logic            ramREN,
  output word_t           ramaddr,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  iarb_state_t state, state_d;
  logic        owner, owner_d;
  logic        last, last_d;
  word_t       addr_q, addr_d;
  logic [1:0]  gnt;

  rr_arb2 u_rr (
    .req  (iREN),
    .last (last),
    .gnt  (gnt)
  );

  // State, owner, round-robin pointer and captured fill address.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= RESET_LAST;
      addr_q <= '0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      last   <= last_d;
      addr_q <= addr_d;
    end
  end

  // Next state and combinational handshake decode; outputs stay at defaults while in reset.
  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last;
    addr_d  = addr_q;
    iwait   = 2'b11;
    iload0  = '0;
    iload1  = '0;
    ramREN  = 1'b0;
    ramaddr = '0;
    ibusy   = 1'b0;

    if (nRST) begin
      case (state)
        IDLE: begin
          // Data side has priority only at fill start.
          if (!dbusy && (iREN != 2'b00)) begin
            owner_d = gnt[1];
            addr_d  = gnt[1] ? iaddr1 : iaddr0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          ramREN  = 1'b1;
          ramaddr = addr_q;
          ibusy   = 1'b1;
          if (!iREN[owner]) begin
            state_d = IDLE;
          end else if (ramstate == ACCESS) begin
            iwait[owner] = 1'b0;
            if (owner) iload1 = ramload;
            else       iload0 = ramload;
            last_d  = owner;
            state_d = IDLE;
          end
          // FREE/BUSY/ERROR: keep reissuing the same read.
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_arbiter.sv
// Self-checking bench for icache_arbiter: directed scenarios then randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_icache_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic [1:0] iREN;
  word_t     iaddr0, iaddr1;
  logic [1:0] iwait;
  word_t     iload0, iload1;
  logic      dbusy, ibusy, ramREN;
  word_t     ramaddr, ramload;
  ramstate_t ramstate;

  always #5 CLK = ~CLK;

  icache_arbiter #(.CPUS(2), .RESET_LAST(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .iwait(iwait), .iload0(iload0), .iload1(iload1), .dbusy(dbusy), .ibusy(ibusy),
    .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one fill in flight, owned by a core, plus the core served last.
  bit    m_busy = 1'b0;
  int    m_core = 0;
  word_t m_addr = '0;
  int    m_last = 1;
  logic [1:0] exp_done = 2'b00;

  // Observations taken from the DUT for directed checks.
  int    obs_done[2] = '{0, 0};
  word_t obs_load0 = '0;
  int    ibusy_cycles = 0;
  int    both_low = 0;
  int    order[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs at negedge, then advance the model at posedge.
  task automatic step();
    logic [1:0] e_wait;
    word_t      e_l0, e_l1, e_addr;
    logic       e_ren;
    @(negedge CLK);
    e_wait = 2'b11; e_l0 = '0; e_l1 = '0; e_addr = '0; e_ren = 1'b0;
    exp_done = 2'b00;
    if (nRST && m_busy) begin
      e_ren  = 1'b1;
      e_addr = m_addr;
      if (iREN[m_core] && ramstate == ACCESS) begin
        exp_done[m_core] = 1'b1;
        e_wait[m_core]   = 1'b0;
        if (m_core == 1) e_l1 = ramload; else e_l0 = ramload;
      end
    end
    chk("iwait",   32'(iwait),  32'(e_wait));
    chk("iload0",  iload0,      e_l0);
    chk("iload1",  iload1,      e_l1);
    chk("ramREN",  32'(ramREN), 32'(e_ren));
    chk("ramaddr", ramaddr,     e_addr);
    chk("ibusy",   32'(ibusy),  32'(e_ren));
    if (ibusy) ibusy_cycles++;
    if (iwait == 2'b00) both_low++;
    if (!iwait[0]) begin obs_done[0]++; obs_load0 = iload0; order.push_back(0); end
    if (!iwait[1]) begin obs_done[1]++; order.push_back(1); end

    @(posedge CLK);
    if (!nRST) begin
      m_busy = 1'b0;
      m_last = 1;
    end else if (m_busy) begin
      if (!iREN[m_core]) m_busy = 1'b0;
      else if (ramstate == ACCESS) begin
        m_busy = 1'b0;
        m_last = m_core;
      end
    end else if (!dbusy && iREN != 2'b00) begin
      m_core = (iREN == 2'b11) ? 1 - m_last : (iREN[1] ? 1 : 0);
      m_addr = (m_core == 1) ? iaddr1 : iaddr0;
      m_busy = 1'b1;
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int d0, d1;

  initial begin
    nRST = 1'b0; iREN = 2'b11; iaddr0 = '0; iaddr1 = '0;
    dbusy = 1'b0; ramload = '0; ramstate = FREE;

    // Reset held two cycles with both cores requesting.
    steps(2);
    chk("rst_iwait",  32'(iwait),  32'h3);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ibusy",  32'(ibusy),  32'h0);

    // Single fill, three BUSY cycles then ACCESS.
    nRST = 1'b1; iREN = 2'b01; iaddr0 = 32'h0000_0040; ramstate = BUSY;
    ibusy_cycles = 0; d0 = obs_done[0];
    step();
    chk("single_ramaddr", ramaddr, 32'h0000_0040);
    steps(3);
    ramstate = ACCESS; ramload = 32'h2408_0001;
    step();
    chk("single_done",  32'(obs_done[0] - d0), 32'd1);
    chk("single_load",  obs_load0, 32'h2408_0001);
    iREN = 2'b00; ramstate = FREE;
    step();
    chk("single_ibusy", 32'(ibusy_cycles), 32'd4);

    // Contention from reset with RAM always ready: grants alternate 0,1,0,1.
    nRST = 1'b0; iREN = 2'b11;
    step();
    nRST = 1'b1; ramstate = ACCESS; iaddr0 = 32'h1000; iaddr1 = 32'h2000;
    order.delete(); both_low = 0;
    steps(8);
    chk("cont_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("cont_order", 32'(order[i]), 32'(i % 2));
    chk("cont_both_low", 32'(both_low), 32'd0);

    // dbusy blocks fill start, is ignored once the fill is running.
    iREN = 2'b00; ramstate = BUSY;
    step();
    dbusy = 1'b1; iREN = 2'b01; iaddr0 = 32'h0000_0100;
    steps(5);
    chk("dbusy_hold", 32'(ramREN), 32'h0);
    dbusy = 1'b0;
    step();
    chk("dbusy_release", 32'(ramREN), 32'h1);
    dbusy = 1'b1; d0 = obs_done[0];
    steps(2);
    ramstate = ACCESS;
    step();
    chk("dbusy_midfill_done", 32'(obs_done[0] - d0), 32'd1);
    iREN = 2'b00; dbusy = 1'b0; ramstate = BUSY;
    step();

    // Abort: core 1 drops its request mid-fill; pointer still favours core 1 afterwards.
    iREN = 2'b10; iaddr1 = 32'h0000_0200; d1 = obs_done[1];
    steps(2);
    iREN = 2'b00;
    step();
    chk("abort_ibusy", 32'(ibusy), 32'h0);
    chk("abort_nodone", 32'(obs_done[1] - d1), 32'd0);
    iREN = 2'b11; ramstate = ACCESS; order.delete();
    steps(2);
    chk("abort_regrant", order.size() > 0 ? 32'(order[0]) : 32'hFFFF_FFFF, 32'd1);
    iREN = 2'b00;
    step();

    // ERROR is a retry, never a completion.
    iREN = 2'b01; ramstate = ERROR; d0 = obs_done[0];
    steps(3);
    chk("error_nodone", 32'(obs_done[0] - d0), 32'd0);
    ramstate = ACCESS;
    step();
    iREN = 2'b00;
    step();
    chk("error_one_done", 32'(obs_done[0] - d0), 32'd1);

    // Reset mid-fill drops the fill without a completion pulse.
    iREN = 2'b01; ramstate = BUSY; d0 = obs_done[0];
    steps(2);
    nRST = 1'b0; ramstate = ACCESS;
    step();
    nRST = 1'b1; iREN = 2'b00;
    step();
    chk("rstfill_nodone", 32'(obs_done[0] - d0), 32'd0);
    chk("rstfill_idle",   32'(ibusy), 32'h0);

    // Randomized traffic obeying the request protocol.
    for (int c = 0; c < 3000; c++) begin
      nRST     = ($urandom_range(0, 199) != 0);
      dbusy    = ($urandom_range(0, 3) == 0);
      ramstate = ramstate_t'(2'($urandom_range(0, 3)));
      ramload  = $urandom;
      for (int n = 0; n < 2; n++) begin
        logic  req;
        logic  new_addr;
        req = iREN[n];
        new_addr = 1'b0;
        if (!req) begin
          if ($urandom_range(0, 2) == 0) begin req = 1'b1; new_addr = 1'b1; end
        end else if (exp_done[n]) begin
          if ($urandom_range(0, 1) == 0) req = 1'b0;
          else new_addr = 1'b1;
        end else if ($urandom_range(0, 49) == 0) begin
          req = 1'b0;
        end
        iREN[n] = req;
        if (new_addr) begin
          if (n == 0) iaddr0 = $urandom;
          else        iaddr1 = $urandom;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
